// File: rtl/qpu_exu_event_queue.sv
// Timestamped event FIFO: each queued event is issued when the timeline counter reaches its tdata.
// Optional macro QPU_EVQ_LATE_ERR_EN traps a late head in an ERR state instead of issuing it.
`ifndef QPU_EVENT_WIRE_WIDTH
`define QPU_EVENT_WIRE_WIDTH 16
`endif
`ifndef QPU_EVENT_NUM
`define QPU_EVENT_NUM 4
`endif
`ifndef QPU_TIME_WIDTH
`define QPU_TIME_WIDTH 8
`endif

module qpu_exu_event_queue #(
    parameter int EVQ_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             evq_start,
    input  logic                             evq_stop,
    input  logic                             evq_flush,
    input  logic                             evq_i_valid,
    output logic                             evq_i_ready,
    input  logic [`QPU_EVENT_WIRE_WIDTH-1:0] evq_i_edata,
    input  logic [`QPU_EVENT_NUM-1:0]        evq_i_oprand,
    input  logic [`QPU_TIME_WIDTH-1:0]       evq_i_tdata,
    output logic [`QPU_TIME_WIDTH-1:0]       evq_o_time,
    output logic                             evq_o_valid,
    output logic [`QPU_EVENT_WIRE_WIDTH-1:0] evq_o_edata,
    output logic [`QPU_EVENT_NUM-1:0]        evq_o_oprand,
    output logic [$clog2(EVQ_DEPTH):0]       evq_o_cnt,
    output logic                             evq_o_late_err,
    input  logic                             evq_err_clr
);

    localparam int PTR_W = $clog2(EVQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TW    = `QPU_TIME_WIDTH;
    localparam int EW    = `QPU_EVENT_WIRE_WIDTH;
    localparam int NW    = `QPU_EVENT_NUM;

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    state_t           state;
    logic [EW-1:0]    edata_mem [EVQ_DEPTH];
    logic [NW-1:0]    oprand_mem [EVQ_DEPTH];
    logic [TW-1:0]    tdata_mem [EVQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic [TW-1:0]    head_tdata;
    logic [TW-1:0]    diff;
    logic             has_head;
    logic             head_match;
    logic             head_late;
    logic             push;
    logic             pop;
    logic             fifo_clear;

    assign evq_o_cnt   = cnt;
    assign evq_i_ready = (cnt != CNT_W'(EVQ_DEPTH)) && (state != ERR);
    assign push        = evq_i_valid && evq_i_ready && !evq_flush;

    // Head is judged from registered storage only, so a fresh push waits one cycle.
    assign head_tdata  = tdata_mem[rd_ptr];
    assign diff        = head_tdata - evq_o_time;
    assign head_match  = (diff == '0);
    assign head_late   = diff[TW-1];
    assign has_head    = (state == RUN) && (cnt != '0) && !evq_flush;

`ifdef QPU_EVQ_LATE_ERR_EN
    logic late_trap;
    assign pop        = has_head && head_match;
    assign late_trap  = has_head && head_late;
    assign fifo_clear = evq_flush || ((state == ERR) && evq_err_clr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evq_o_late_err <= 1'b0;
        end else if ((state == ERR) && evq_err_clr) begin
            evq_o_late_err <= 1'b0;
        end else if (late_trap) begin
            evq_o_late_err <= 1'b1;
        end
    end
`else
    logic late_trap;
    logic unused_err_clr;
    assign pop            = has_head && (head_match || head_late);
    assign late_trap      = 1'b0;
    assign fifo_clear     = evq_flush;
    assign evq_o_late_err = 1'b0;
    assign unused_err_clr = evq_err_clr;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            edata_mem[wr_ptr]  <= evq_i_edata;
            oprand_mem[wr_ptr] <= evq_i_oprand;
            tdata_mem[wr_ptr]  <= evq_i_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            evq_o_time   <= '0;
            cnt          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            evq_o_valid  <= 1'b0;
            evq_o_edata  <= '0;
            evq_o_oprand <= '0;
        end else begin
            evq_o_valid <= pop;
            if (pop) begin
                evq_o_edata  <= edata_mem[rd_ptr];
                evq_o_oprand <= oprand_mem[rd_ptr];
            end

            case (state)
                IDLE: begin
                    if (evq_start) begin
                        state      <= RUN;
                        evq_o_time <= '0;
                    end
                end
                RUN: begin
                    if (evq_stop) begin
                        state <= IDLE;
                    end else begin
                        evq_o_time <= evq_o_time + 1'b1;
                        if (late_trap) state <= ERR;
                    end
                end
                ERR: begin
                    if (evq_err_clr && fifo_clear) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Flush or error clear wins over any same-cycle push/pop.
            if (fifo_clear) begin
                cnt    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qpu_exu_event_queue.sv
// Directed self-checking bench for qpu_exu_event_queue (EVQ_DEPTH=4, 8-bit timeline).
`ifndef QPU_EVENT_WIRE_WIDTH
`define QPU_EVENT_WIRE_WIDTH 16
`endif
`ifndef QPU_EVENT_NUM
`define QPU_EVENT_NUM 4
`endif
`ifndef QPU_TIME_WIDTH
`define QPU_TIME_WIDTH 8
`endif

module tb_qpu_exu_event_queue;

    localparam int DEPTH = 4;
    localparam int TW    = `QPU_TIME_WIDTH;
    localparam int EW    = `QPU_EVENT_WIRE_WIDTH;
    localparam int NW    = `QPU_EVENT_NUM;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              evq_start = 1'b0;
    logic              evq_stop = 1'b0;
    logic              evq_flush = 1'b0;
    logic              evq_i_valid = 1'b0;
    logic              evq_i_ready;
    logic [EW-1:0]     evq_i_edata = '0;
    logic [NW-1:0]     evq_i_oprand = '0;
    logic [TW-1:0]     evq_i_tdata = '0;
    logic [TW-1:0]     evq_o_time;
    logic              evq_o_valid;
    logic [EW-1:0]     evq_o_edata;
    logic [NW-1:0]     evq_o_oprand;
    logic [$clog2(DEPTH):0] evq_o_cnt;
    logic              evq_o_late_err;
    logic              evq_err_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    qpu_exu_event_queue #(.EVQ_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .evq_start      (evq_start),
        .evq_stop       (evq_stop),
        .evq_flush      (evq_flush),
        .evq_i_valid    (evq_i_valid),
        .evq_i_ready    (evq_i_ready),
        .evq_i_edata    (evq_i_edata),
        .evq_i_oprand   (evq_i_oprand),
        .evq_i_tdata    (evq_i_tdata),
        .evq_o_time     (evq_o_time),
        .evq_o_valid    (evq_o_valid),
        .evq_o_edata    (evq_o_edata),
        .evq_o_oprand   (evq_o_oprand),
        .evq_o_cnt      (evq_o_cnt),
        .evq_o_late_err (evq_o_late_err),
        .evq_err_clr    (evq_err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [EW-1:0] e, input logic [NW-1:0] o, input logic [TW-1:0] t);
        evq_i_valid  = 1'b1;
        evq_i_edata  = e;
        evq_i_oprand = o;
        evq_i_tdata  = t;
        step();
        evq_i_valid  = 1'b0;
    endtask

    initial begin
        int npulse;
        int p_time [8];
        int p_data [8];
        int seen_time;
        int frozen;

        // Reset state
        step();
        step();
        rst_n = 1'b1;
        check("rst_time", evq_o_time, 0);
        check("rst_cnt", evq_o_cnt, 0);
        check("rst_valid", evq_o_valid, 0);
        check("rst_edata", evq_o_edata, 0);
        check("rst_oprand", evq_o_oprand, 0);
        check("rst_late_err", evq_o_late_err, 0);
        check("rst_ready", evq_i_ready, 1);

        // Single event at tdata=5 issues once, seen with time 6
        push(16'hA5A5, 4'h9, 8'd5);
        check("single_cnt", evq_o_cnt, 1);
        evq_start = 1'b1;
        step();
        evq_start = 1'b0;
        check("start_time0", evq_o_time, 0);
        npulse = 0;
        seen_time = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (evq_o_valid) begin
                npulse++;
                seen_time = evq_o_time;
                check("single_edata", evq_o_edata, 16'hA5A5);
                check("single_oprand", evq_o_oprand, 4'h9);
            end
        end
        check("single_npulse", npulse, 1);
        check("single_time", seen_time, 6);
        check("single_cnt_after", evq_o_cnt, 0);
        check("run_time10", evq_o_time, 10);

        // Stop freezes the timeline
        evq_stop = 1'b1;
        step();
        evq_stop = 1'b0;
        step();
        step();
        check("stop_frozen", evq_o_time, 10);

        // Fill to depth: ready drops at cnt=4, extra push rejected
        push(16'h0011, 4'h1, 8'd3);
        push(16'h0022, 4'h2, 8'd4);
        push(16'h0033, 4'h3, 8'd4);
        check("fill_ready_at3", evq_i_ready, 1);
        push(16'h0044, 4'h4, 8'd9);
        check("full_cnt", evq_o_cnt, 4);
        check("full_ready", evq_i_ready, 0);
        push(16'h00EE, 4'hE, 8'd7);
        check("full_reject_cnt", evq_o_cnt, 4);
        check("idle_no_issue", evq_o_valid, 0);

        // Run the filled queue: match at 3 and 4, then a late second tdata=4
        evq_start = 1'b1;
        step();
        evq_start = 1'b0;
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (evq_o_valid && npulse < 8) begin
                p_time[npulse] = evq_o_time;
                p_data[npulse] = evq_o_edata;
                npulse++;
            end
        end
        check("seq_p0_time", p_time[0], 4);
        check("seq_p0_data", p_data[0], 16'h0011);
        check("seq_p1_time", p_time[1], 5);
        check("seq_p1_data", p_data[1], 16'h0022);
`ifdef QPU_EVQ_LATE_ERR_EN
        check("late_npulse", npulse, 2);
        check("late_err_set", evq_o_late_err, 1);
        check("late_err_ready", evq_i_ready, 0);
        check("late_err_cnt", evq_o_cnt, 2);
        check("late_err_time", evq_o_time, 6);
        evq_err_clr = 1'b1;
        step();
        evq_err_clr = 1'b0;
        check("errclr_cnt", evq_o_cnt, 0);
        check("errclr_flag", evq_o_late_err, 0);
        check("errclr_ready", evq_i_ready, 1);
`else
        check("late_npulse", npulse, 4);
        check("late_p2_time", p_time[2], 6);
        check("late_p2_data", p_data[2], 16'h0033);
        check("late_p3_time", p_time[3], 10);
        check("late_p3_data", p_data[3], 16'h0044);
        check("late_err_tied", evq_o_late_err, 0);
        evq_stop = 1'b1;
        evq_err_clr = 1'b1;
        step();
        evq_stop = 1'b0;
        evq_err_clr = 1'b0;
        check("seq_cnt_empty", evq_o_cnt, 0);
`endif

        // Wrap: head tdata=1 while the timer sits at 2^W-2 is not late
        evq_start = 1'b1;
        step();
        evq_start = 1'b0;
        for (int i = 0; i < 300 && evq_o_time != 8'd253; i++) step();
        check("wrap_reach", evq_o_time, 253);
        push(16'h0055, 4'h5, 8'd1);
        check("wrap_time254", evq_o_time, 254);
        check("wrap_cnt", evq_o_cnt, 1);
        seen_time = -1;
        for (int i = 0; i < 10 && seen_time < 0; i++) begin
            step();
            if (evq_o_valid) seen_time = evq_o_time;
        end
        check("wrap_issue_time", seen_time, 2);
        check("wrap_edata", evq_o_edata, 16'h0055);
        check("wrap_no_err", evq_o_late_err, 0);
        step();
        check("wrap_pulse_1cyc", evq_o_valid, 0);

        // Full queue, head matches while a push is offered: pop only
        evq_stop = 1'b1;
        step();
        evq_stop = 1'b0;
        push(16'h0066, 4'h6, 8'd2);
        push(16'h0067, 4'h7, 8'd100);
        push(16'h0068, 4'h8, 8'd101);
        push(16'h0069, 4'hA, 8'd102);
        evq_start = 1'b1;
        step();
        evq_start = 1'b0;
        step();
        step();
        check("pp_time2", evq_o_time, 2);
        check("pp_no_early", evq_o_valid, 0);
        evq_i_valid  = 1'b1;
        evq_i_edata  = 16'h0077;
        evq_i_oprand = 4'hB;
        evq_i_tdata  = 8'd3;
        check("pp_ready_low", evq_i_ready, 0);
        step();
        evq_i_valid = 1'b0;
        check("pp_cnt3", evq_o_cnt, 3);
        check("pp_valid", evq_o_valid, 1);
        check("pp_edata", evq_o_edata, 16'h0066);

        // Reset mid-RUN with three queued entries
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mrst_time", evq_o_time, 0);
        check("mrst_cnt", evq_o_cnt, 0);
        check("mrst_valid", evq_o_valid, 0);
        check("mrst_edata", evq_o_edata, 0);
        check("mrst_oprand", evq_o_oprand, 0);
        check("mrst_late_err", evq_o_late_err, 0);
        npulse = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (evq_o_valid) npulse++;
        end
        check("mrst_no_pulse", npulse, 0);
        check("mrst_time_idle", evq_o_time, 0);

        // Flush overrides a same-cycle push; time unaffected
        push(16'h0101, 4'h1, 8'd9);
        push(16'h0202, 4'h2, 8'd9);
        check("fl_cnt_pre", evq_o_cnt, 2);
        evq_flush    = 1'b1;
        evq_i_valid  = 1'b1;
        evq_i_edata  = 16'h0303;
        evq_i_tdata  = 8'd9;
        step();
        evq_flush   = 1'b0;
        evq_i_valid = 1'b0;
        check("fl_cnt", evq_o_cnt, 0);
        check("fl_ready", evq_i_ready, 1);

        // Flush in RUN on the match cycle suppresses the issue
        push(16'h0404, 4'h4, 8'd2);
        evq_start = 1'b1;
        step();
        evq_start = 1'b0;
        step();
        step();
        frozen = evq_o_time;
        check("flrun_time2", frozen, 2);
        evq_flush = 1'b1;
        step();
        evq_flush = 1'b0;
        check("flrun_no_pulse", evq_o_valid, 0);
        check("flrun_cnt", evq_o_cnt, 0);
        check("flrun_time_runs", evq_o_time, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
